// File: rtl/vector_assembler_pkg.sv
// vector_assembler_pkg: shared definitions (`WIDTH, default SIZE, slot encodings, FSM states)
`ifndef WIDTH
`define WIDTH 32
`endif

package vector_assembler_pkg;
   localparam int DEFAULT_SIZE = `WIDTH;
   localparam logic [2:0] SLOT_X = 3'b001;
   localparam logic [2:0] SLOT_Y = 3'b010;
   localparam logic [2:0] SLOT_Z = 3'b100;
   typedef enum logic {COLLECT, FULL} state_t;
endpackage

// File: rtl/vector_slot_ring.sv
// vector_slot_ring: one-hot X->Y->Z write-slot rotator, advances on Enable
module vector_slot_ring
   import vector_assembler_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Enable,
   output logic [2:0] slot
);
   // rotate the one-hot slot on every accepted word
   always_ff @(posedge Clock)
      if (Reset) slot <= SLOT_X;
      else if (Enable) slot <= {slot[1:0], slot[2]};
endmodule

// File: rtl/vector_assembler.sv
// vector_assembler: packs X,Y,Z words into a 3-word vector; VECTOR_ASSEMBLER_TIMEOUT_EN adds a partial-vector timeout
module vector_assembler
   import vector_assembler_pkg::*;
#(
   parameter int SIZE           = DEFAULT_SIZE,
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iWordValid,
   output logic              oWordReady,
   input  logic [SIZE-1:0]   iWord,
   output logic              oVectorValid,
   input  logic              iVectorReady,
   output logic [3*SIZE-1:0] oVector,
   output logic              oTimeout
);
   state_t          state, state_nx;
   logic [2:0]      slot;
   logic            accept, consume, ring_rst;
   logic [SIZE-1:0] x, y, z;

   assign oVectorValid = (state == FULL);
   assign oWordReady   = !oVectorValid || iVectorReady;
   assign accept       = iWordValid && oWordReady;
   assign consume      = oVectorValid && iVectorReady;
   assign oVector      = {x, y, z};

   vector_slot_ring u_ring (
      .Clock (Clock),
      .Reset (ring_rst),
      .Enable(accept),
      .slot  (slot)
   );

   // FULL after the Z word lands; any consume drops back to COLLECT (a same-cycle X accept keeps streaming)
   always_comb begin
      state_nx = state;
      if (state == COLLECT) state_nx = (accept && slot == SLOT_Z) ? FULL : COLLECT;
      else state_nx = consume ? COLLECT : FULL;
   end

   // state register
   always_ff @(posedge Clock)
      if (Reset) state <= COLLECT;
      else state <= state_nx;

   // component registers load only when their slot accepts a word
   always_ff @(posedge Clock)
      if (Reset) begin
         x <= '0;
         y <= '0;
         z <= '0;
      end else if (accept) begin
         if (slot[0]) x <= iWord;
         if (slot[1]) y <= iWord;
         if (slot[2]) z <= iWord;
      end

`ifdef VECTOR_ASSEMBLER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   logic          fire;
   assign fire     = slot != SLOT_X && state == COLLECT && !accept && (cnt + CW'(1)) == CW'(TIMEOUT_CYCLES);
   assign ring_rst = Reset || fire;
   // idle counter while a vector is partly filled; expiry rewinds the slot and pulses oTimeout
   always_ff @(posedge Clock)
      if (Reset) begin
         cnt      <= '0;
         oTimeout <= 1'b0;
      end else begin
         oTimeout <= fire;
         cnt      <= (fire || accept || slot == SLOT_X || state != COLLECT) ? '0 : cnt + CW'(1);
      end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign ring_rst       = Reset;
   assign oTimeout       = 1'b0;
`endif
endmodule

// File: tb/tb_vector_assembler.sv
// tb_vector_assembler: directed bench with word-count model; honours VECTOR_ASSEMBLER_TIMEOUT_EN
module tb_vector_assembler;
   localparam int W  = 32;
   localparam int TO = 4;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          iWordValid = 1'b0;
   logic          oWordReady;
   logic [W-1:0]  iWord = '0;
   logic          oVectorValid;
   logic          iVectorReady = 1'b0;
   logic [3*W-1:0] oVector;
   logic          oTimeout;

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;
   int tcount = 0;
   logic [3*W-1:0] got[$];

   vector_assembler #(.SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
      .Clock(Clock), .Reset(Reset), .iWordValid(iWordValid), .oWordReady(oWordReady),
      .iWord(iWord), .oVectorValid(oVectorValid), .iVectorReady(iVectorReady),
      .oVector(oVector), .oTimeout(oTimeout)
   );

   always #5 Clock = ~Clock;

   // model: words collected so far, a vector is complete after three accepts
   logic         m_valid = 0;
   logic [W-1:0] m_c0 = '0, m_c1 = '0, m_c2 = '0;
   int           m_n = 0;
   int           m_idle = 0;
   logic         m_tout = 0;

   always @(posedge Clock) begin : model
      logic rdy, acc, v, t;
      int n, idle;
      if (Reset) begin
         m_valid <= 0; m_c0 <= '0; m_c1 <= '0; m_c2 <= '0;
         m_n <= 0; m_idle <= 0; m_tout <= 0;
      end else begin
         rdy = !m_valid || iVectorReady;
         acc = iWordValid && rdy;
         v = m_valid && !iVectorReady;
         n = m_n; idle = m_idle; t = 0;
         if (acc) begin
            if (n == 0) m_c0 <= iWord;
            if (n == 1) m_c1 <= iWord;
            if (n == 2) m_c2 <= iWord;
            n = n + 1;
            idle = 0;
            if (n == 3) begin n = 0; v = 1; end
         end else if (n != 0) begin
`ifdef VECTOR_ASSEMBLER_TIMEOUT_EN
            idle = idle + 1;
            if (idle == TO) begin n = 0; idle = 0; t = 1; end
`endif
         end
         m_valid <= v; m_n <= n; m_idle <= idle; m_tout <= t;
      end
   end

   task automatic chk(input string name, input logic [3*W-1:0] act, input logic [3*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // compare DUT against the model every cycle, and log consumed vectors / timeout pulses
   always @(negedge Clock) if (chk_on) begin
      chk("ready", 96'(oWordReady), 96'(!m_valid || iVectorReady));
      chk("valid", 96'(oVectorValid), 96'(m_valid));
      chk("vector", oVector, {m_c0, m_c1, m_c2});
      chk("timeout", 96'(oTimeout), 96'(m_tout));
      if (oVectorValid && iVectorReady) got.push_back(oVector);
      if (oTimeout) tcount++;
   end

   task automatic cyc(input logic rst, input logic v, input logic [W-1:0] w, input logic r);
      Reset = rst; iWordValid = v; iWord = w; iVectorReady = r;
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [3*W-1:0] vec(input logic [W-1:0] a, b, c);
      return {a, b, c};
   endfunction

   initial begin
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("rst_valid", 96'(oVectorValid), 96'(0));
      chk("rst_vector", oVector, 96'(0));
      chk("rst_ready", 96'(oWordReady), 96'(1));
      chk("rst_timeout", 96'(oTimeout), 96'(0));
      chk_on = 1;

      cyc(0, 1, 32'h11, 0);
      cyc(0, 1, 32'h22, 0);
      cyc(0, 1, 32'h33, 0);
      chk("basic_valid", 96'(oVectorValid), 96'(1));
      chk("basic_vector", oVector, 96'h00000011_00000022_00000033);
      chk("basic_ready", 96'(oWordReady), 96'(0));
      chk("basic_model", {m_c0, m_c1, m_c2}, 96'h00000011_00000022_00000033);

      for (int i = 0; i < 10; i++) cyc(0, 1, 32'hdead_0000 + 32'(i), 0);
      chk("bp_valid", 96'(oVectorValid), 96'(1));
      chk("bp_vector", oVector, 96'h00000011_00000022_00000033);
      cyc(0, 0, 0, 1);
      chk("consume_valid", 96'(oVectorValid), 96'(0));

      got.delete();
      for (int i = 1; i <= 9; i++) begin
         cyc(0, 1, 32'(i), 1);
         chk("stream_ready", 96'(oWordReady), 96'(1));
      end
      cyc(0, 0, 0, 1);
      chk("stream_count", 96'(got.size()), 96'(3));
      if (got.size() == 3) begin
         chk("stream_v0", got[0], vec(1, 2, 3));
         chk("stream_v1", got[1], vec(4, 5, 6));
         chk("stream_v2", got[2], vec(7, 8, 9));
      end

      cyc(0, 1, 32'hA, 0);
      cyc(0, 1, 32'hB, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 32'h1, 0);
      cyc(0, 1, 32'h2, 0);
      cyc(0, 1, 32'h3, 0);
      chk("rstmid_valid", 96'(oVectorValid), 96'(1));
      chk("rstmid_vector", oVector, vec(1, 2, 3));
      chk("rstmid_no_timeout", 96'(tcount), 96'(0));
      cyc(0, 0, 0, 1);

      cyc(0, 1, 32'h5, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
      cyc(0, 1, 32'h7, 0);
      cyc(0, 1, 32'h8, 0);
`ifdef VECTOR_ASSEMBLER_TIMEOUT_EN
      cyc(0, 1, 32'h9, 0);
      chk("to_pulses", 96'(tcount), 96'(1));
      chk("to_vector", oVector, vec(7, 8, 9));
`else
      chk("to_pulses", 96'(tcount), 96'(0));
      chk("to_vector", oVector, vec(5, 7, 8));
`endif
      chk("to_valid", 96'(oVectorValid), 96'(1));
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
